// File: rtl/bp_me_cce_lat_stats.sv
// bp_me_cce_lat_stats
// Multi-outstanding CCE request latency tracker. Follows up to num_slots_p
// in-flight LCE requests by LCE id. For each op (RD/WR/UC_RD/UC_WR) it keeps
// the completed count and the total, minimum and maximum latency. It also
// raises sticky flags on protocol anomalies. It only observes the CCE and
// never applies backpressure.
//
// Ports
//   clk_i, reset_n_i          clock, synchronous active-low reset
//   start_v/id/op_i           a request begins (op: 0=RD 1=WR 2=UC_RD 3=UC_WR)
//   end_v/id_i                a request completes
//   clr_i                     clear statistics and sticky flags (slots kept)
//   rd_op_i                   op whose statistics drive count/sum/min/max_o
//   count_o/sum_o/min_o/max_o statistics for rd_op_i
//   busy_o                    slot-valid vector
//   overflow_o/dup_o/orphan_o sticky anomaly flags
module bp_me_cce_lat_stats #(
    parameter int num_slots_p = 4,
    parameter int id_width_p  = 4,
    parameter int cnt_width_p = 32,
    parameter int sum_width_p = 48
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   start_v_i,
    input  logic [id_width_p-1:0]  start_id_i,
    input  logic [1:0]             start_op_i,
    input  logic                   end_v_i,
    input  logic [id_width_p-1:0]  end_id_i,
    input  logic                   clr_i,
    input  logic [1:0]             rd_op_i,
    output logic [cnt_width_p-1:0] count_o,
    output logic [sum_width_p-1:0] sum_o,
    output logic [cnt_width_p-1:0] min_o,
    output logic [cnt_width_p-1:0] max_o,
    output logic [num_slots_p-1:0] busy_o,
    output logic                   overflow_o,
    output logic                   dup_o,
    output logic                   orphan_o
);

    function automatic logic [cnt_width_p-1:0] sat_inc(input logic [cnt_width_p-1:0] v);
        return (v == {cnt_width_p{1'b1}}) ? v : v + {{(cnt_width_p-1){1'b0}}, 1'b1};
    endfunction

    logic [num_slots_p-1:0] valid_r;
    logic [id_width_p-1:0]  id_r  [num_slots_p];
    logic [1:0]             op_r  [num_slots_p];
    logic [cnt_width_p-1:0] age_r [num_slots_p];

    logic [num_slots_p-1:0] retire_s;
    logic [num_slots_p-1:0] alloc_s;
    logic [num_slots_p-1:0] free_s;
    logic                   hit_s;
    logic                   dup_s;
    logic                   ovf_s;
    logic [1:0]             hit_op_s;
    logic [cnt_width_p-1:0] hit_lat_s;

    logic                   lat_v_r;
    logic [1:0]             lat_op_r;
    logic [cnt_width_p-1:0] lat_r;

    logic [cnt_width_p-1:0] count_r [4];
    logic [sum_width_p-1:0] sum_r   [4];
    logic [cnt_width_p-1:0] min_r   [4];
    logic [cnt_width_p-1:0] max_r   [4];

    logic [sum_width_p:0]   sum_ext_s;
    logic [sum_width_p-1:0] sum_next_s;

    logic                   overflow_r;
    logic                   dup_r;
    logic                   orphan_r;

    // End match, duplicate detection and lowest-index free-slot allocation.
    // The age register holds L-1 on the cycle a request ends, so the latency
    // is age+1 (saturating). That makes the minimum latency 1.
    always_comb begin
        logic found;
        logic [num_slots_p-1:0] inflight;
        found     = 1'b0;
        inflight  = '0;
        retire_s  = '0;
        alloc_s   = '0;
        hit_op_s  = 2'b00;
        hit_lat_s = '0;
        for (int i = 0; i < num_slots_p; i++) begin
            retire_s[i] = end_v_i & valid_r[i] & (id_r[i] == end_id_i);
            hit_op_s    = hit_op_s | ({2{retire_s[i]}} & op_r[i]);
            hit_lat_s   = hit_lat_s | ({cnt_width_p{retire_s[i]}} & sat_inc(age_r[i]));
        end
        hit_s  = |retire_s;
        free_s = ~valid_r | retire_s;
        for (int i = 0; i < num_slots_p; i++) begin
            inflight[i] = valid_r[i] & ~retire_s[i] & (id_r[i] == start_id_i);
        end
        dup_s = start_v_i & (|inflight);
        ovf_s = start_v_i & ~dup_s & ~(|free_s);
        for (int i = 0; i < num_slots_p; i++) begin
            alloc_s[i] = start_v_i & ~dup_s & free_s[i] & ~found;
            found      = found | free_s[i];
        end
    end

    // Slot state: allocate, retire, or age the valid slots with saturation.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            valid_r <= '0;
            for (int i = 0; i < num_slots_p; i++) begin
                id_r[i]  <= '0;
                op_r[i]  <= 2'b00;
                age_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < num_slots_p; i++) begin
                if (alloc_s[i]) begin
                    valid_r[i] <= 1'b1;
                    id_r[i]    <= start_id_i;
                    op_r[i]    <= start_op_i;
                    age_r[i]   <= '0;
                end else if (retire_s[i]) begin
                    valid_r[i] <= 1'b0;
                end else if (valid_r[i]) begin
                    age_r[i]   <= sat_inc(age_r[i]);
                end
            end
        end
    end

    // One register stage between the end match and the statistics update.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            lat_v_r  <= 1'b0;
            lat_op_r <= 2'b00;
            lat_r    <= '0;
        end else begin
            lat_v_r  <= hit_s;
            lat_op_r <= hit_op_s;
            lat_r    <= hit_lat_s;
        end
    end

    // Saturating accumulate of the registered latency into its op's total.
    always_comb begin
        sum_ext_s  = {1'b0, sum_r[lat_op_r]} + {{(sum_width_p+1-cnt_width_p){1'b0}}, lat_r};
        sum_next_s = sum_ext_s[sum_width_p] ? {sum_width_p{1'b1}} : sum_ext_s[sum_width_p-1:0];
    end

    // Per-op statistics. A clear takes priority over an update in the same cycle.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i || clr_i) begin
            for (int k = 0; k < 4; k++) begin
                count_r[k] <= '0;
                sum_r[k]   <= '0;
                min_r[k]   <= {cnt_width_p{1'b1}};
                max_r[k]   <= '0;
            end
        end else if (lat_v_r) begin
            count_r[lat_op_r] <= sat_inc(count_r[lat_op_r]);
            sum_r[lat_op_r]   <= sum_next_s;
            if (lat_r < min_r[lat_op_r]) min_r[lat_op_r] <= lat_r;
            if (lat_r > max_r[lat_op_r]) max_r[lat_op_r] <= lat_r;
        end
    end

    // Sticky anomaly flags, cleared together with the statistics.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i || clr_i) begin
            overflow_r <= 1'b0;
            dup_r      <= 1'b0;
            orphan_r   <= 1'b0;
        end else begin
            overflow_r <= overflow_r | ovf_s;
            dup_r      <= dup_r | dup_s;
            orphan_r   <= orphan_r | (end_v_i & ~hit_s);
        end
    end

    assign count_o    = count_r[rd_op_i];
    assign sum_o      = sum_r[rd_op_i];
    assign min_o      = min_r[rd_op_i];
    assign max_o      = max_r[rd_op_i];
    assign busy_o     = valid_r;
    assign overflow_o = overflow_r;
    assign dup_o      = dup_r;
    assign orphan_o   = orphan_r;

endmodule

// File: tb/tb_bp_me_cce_lat_stats.sv
module tb_bp_me_cce_lat_stats;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start_v = 1'b0;
    logic [3:0] start_id = 4'd0;
    logic [1:0] start_op = 2'd0;
    logic       end_v = 1'b0;
    logic [3:0] end_id = 4'd0;
    logic       clr = 1'b0;
    logic [1:0] rd_op = 2'd0;

    logic [31:0] count_w, min_w, max_w;
    logic [47:0] sum_w;
    logic [3:0]  busy_w;
    logic        ovf_w, dup_w, orph_w;

    logic [3:0]  count_n, min_n, max_n;
    logic [7:0]  sum_n;
    logic [3:0]  busy_n;
    logic        ovf_n, dup_n, orph_n;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bp_me_cce_lat_stats dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .start_v_i(start_v), .start_id_i(start_id), .start_op_i(start_op),
        .end_v_i(end_v), .end_id_i(end_id), .clr_i(clr), .rd_op_i(rd_op),
        .count_o(count_w), .sum_o(sum_w), .min_o(min_w), .max_o(max_w),
        .busy_o(busy_w), .overflow_o(ovf_w), .dup_o(dup_w), .orphan_o(orph_w)
    );

    bp_me_cce_lat_stats #(.num_slots_p(4), .id_width_p(4), .cnt_width_p(4), .sum_width_p(8)) dut_n (
        .clk_i(clk), .reset_n_i(reset_n),
        .start_v_i(start_v), .start_id_i(start_id), .start_op_i(start_op),
        .end_v_i(end_v), .end_id_i(end_id), .clr_i(clr), .rd_op_i(rd_op),
        .count_o(count_n), .sum_o(sum_n), .min_o(min_n), .max_o(max_n),
        .busy_o(busy_n), .overflow_o(ovf_n), .dup_o(dup_n), .orphan_o(orph_n)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
    endtask

    task automatic do_start(input logic [3:0] id, input logic [1:0] op);
        start_v = 1'b1; start_id = id; start_op = op;
        tick(1);
        start_v = 1'b0;
    endtask

    task automatic do_end(input logic [3:0] id);
        end_v = 1'b1; end_id = id;
        tick(1);
        end_v = 1'b0;
    endtask

    initial begin
        do_reset();
        // Reset state
        for (int k = 0; k < 4; k++) begin
            rd_op = 2'(k);
            #1;
            check("rst_count", count_w, 64'd0);
            check("rst_sum", sum_w, 64'd0);
            check("rst_min", min_w, 64'hFFFF_FFFF);
            check("rst_max", max_w, 64'd0);
        end
        check("rst_busy", busy_w, 64'd0);
        check("rst_flags", {ovf_w, dup_w, orph_w}, 64'd0);

        // Single RD with latency 7
        rd_op = 2'd0;
        do_start(4'd3, 2'd0);
        tick(6);
        do_end(4'd3);
        check("t1_early_count", count_w, 64'd0);
        tick(1);
        check("t1_count", count_w, 64'd1);
        check("t1_sum", sum_w, 64'd7);
        check("t1_min", min_w, 64'd7);
        check("t1_max", max_w, 64'd7);
        check("t1_busy", busy_w, 64'd0);

        // Overflow and orphan, then mid-flight reset
        do_reset();
        for (int k = 0; k < 4; k++) do_start(4'(k), 2'd0);
        check("t2_noovf", ovf_w, 64'd0);
        do_start(4'd5, 2'd0);
        check("t2_ovf", ovf_w, 64'd1);
        check("t2_busy", busy_w, 64'hF);
        check("t2_noorph", orph_w, 64'd0);
        do_end(4'd5);
        check("t2_orph", orph_w, 64'd1);
        check("t2_busy2", busy_w, 64'hF);
        tick(2);
        check("t2_nostats", count_w, 64'd0);
        do_reset();
        check("t2_rst_busy", busy_w, 64'd0);
        check("t2_rst_flags", {ovf_w, dup_w, orph_w}, 64'd0);

        // Two overlapping WRs: latencies 3 and 9
        rd_op = 2'd1;
        do_start(4'd1, 2'd1);
        do_start(4'd2, 2'd1);
        tick(2);
        do_end(4'd2);
        tick(4);
        do_end(4'd1);
        tick(1);
        check("t3_count", count_w, 64'd2);
        check("t3_sum", sum_w, 64'd12);
        check("t3_min", min_w, 64'd3);
        check("t3_max", max_w, 64'd9);

        // Full slots, same-cycle end and restart of id 2
        do_reset();
        for (int k = 0; k < 4; k++) do_start(4'(k), 2'd0);
        start_v = 1'b1; start_id = 4'd2; start_op = 2'd2;
        end_v = 1'b1; end_id = 4'd2;
        tick(1);
        start_v = 1'b0; end_v = 1'b0;
        check("t4_nodup", dup_w, 64'd0);
        check("t4_noovf", ovf_w, 64'd0);
        check("t4_busy", busy_w, 64'hF);
        tick(4);
        do_end(4'd2);
        tick(1);
        rd_op = 2'd2;
        #1;
        check("t4_ucrd_count", count_w, 64'd1);
        check("t4_ucrd_min", min_w, 64'd5);
        rd_op = 2'd0;
        #1;
        check("t4_rd_count", count_w, 64'd1);
        check("t4_rd_max", max_w, 64'd2);

        // Duplicate start keeps the original age
        do_reset();
        rd_op = 2'd0;
        do_start(4'd4, 2'd0);
        tick(2);
        do_start(4'd4, 2'd0);
        check("t5_dup", dup_w, 64'd1);
        check("t5_busy", busy_w, 64'h1);
        tick(2);
        do_end(4'd4);
        tick(1);
        check("t5_count", count_w, 64'd1);
        check("t5_sum", sum_w, 64'd6);

        // Narrow counter: age saturates at 15; clear beats a landing update
        do_reset();
        rd_op = 2'd0;
        do_start(4'd1, 2'd0);
        tick(19);
        do_end(4'd1);
        tick(1);
        check("t6_count", count_n, 64'd1);
        check("t6_sum", sum_n, 64'd15);
        check("t6_min", min_n, 64'd15);
        check("t6_max", max_n, 64'd15);
        do_end(4'd7);
        check("t6_orph", orph_n, 64'd1);
        do_start(4'd1, 2'd0);
        tick(19);
        do_end(4'd1);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        tick(1);
        check("t6_clr_count", count_n, 64'd0);
        check("t6_clr_min", min_n, 64'hF);
        check("t6_clr_max", max_n, 64'd0);
        check("t6_clr_sum", sum_n, 64'd0);
        check("t6_clr_flags", {ovf_n, dup_n, orph_n}, 64'd0);
        check("t6_clr_wide_count", count_w, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
